// File: rtl/rr_mux8_sched_pkg.sv
// rr_mux8_sched_pkg
//   Shared definitions for the 8-channel round-robin mux scheduler:
//   the channel count, the select width and the scheduler state encoding.
package rr_mux8_sched_pkg;

  localparam int NCH  = 8;
  localparam int SELW = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GUARD = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick8.sv
// rr_pick8
//   Combinational round-robin winner picker. Finds the first set request
//   searching ptr+1, ptr+2, ... with wrap, so ptr itself is searched last.
// Ports:
//   req  in  [7:0]  request vector
//   ptr  in  [2:0]  last granted channel (lowest priority this round)
//   win  out [2:0]  winning channel index (don't-care when any=0)
//   any  out        at least one request is set
module rr_pick8
  import rr_mux8_sched_pkg::*;
(
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] win,
  output logic            any
);

  logic [2*NCH-1:0] dbl;
  logic [NCH-1:0]   rot;
  logic [SELW-1:0]  off;

  // Rotating the doubled vector puts channel ptr+1 at bit 0 and ptr at bit 7.
  assign dbl = {req, req} >> ({1'b0, ptr} + 4'd1);
  assign rot = dbl[NCH-1:0];

  // Lowest set bit of the rotated vector wins.
  always_comb begin
    off = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (rot[k]) off = SELW'(k);
    end
  end

  // Un-rotate; the 3-bit sum wraps modulo 8.
  assign win = ptr + SELW'(1) + off;
  assign any = |req;

endmodule

// File: rtl/rr_mux8_sched.sv
// rr_mux8_sched
//   Round-robin scheduler time-sharing an 8:1 single-bit mux between eight
//   requesters. Each tenancy lasts at most MAX_BURST cycles and is followed
//   by GUARD_CYCLES dead cycles so the select never changes while a
//   downstream consumer is sampling the mux output.
// Ports:
//   clk         in         rising-edge clock
//   rst         in         asynchronous active-high reset
//   en          in         arbitration enable (blocks new tenancies only)
//   req         in  [7:0]  level-held per-channel requests
//   sel         out [2:0]  registered mux select (drives S of the mux)
//   gnt         out [7:0]  registered one-hot grant
//   vld         out        grant active; mux output is meaningful
//   burst_last  out        final grant cycle of a MAX_BURST-length tenancy
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no tenancy; grant the round-robin winner when en and any req
// S_GRANT | channel sel owns the mux; cnt counts cycles of this tenancy
// S_GUARD | dead cycles after a tenancy; gcnt counts down to 1
module rr_mux8_sched
  import rr_mux8_sched_pkg::*;
#(
  parameter int MAX_BURST    = 4,
  parameter int GUARD_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NCH-1:0]  req,
  output logic [SELW-1:0] sel,
  output logic [NCH-1:0]  gnt,
  output logic            vld,
  output logic            burst_last
);

  localparam logic [3:0] MB = 4'(MAX_BURST);
  localparam logic [1:0] GC = 2'(GUARD_CYCLES);

  state_t          state;
  logic [SELW-1:0] ptr;
  logic [3:0]      cnt;
  logic [1:0]      gcnt;

  logic [SELW-1:0] win;
  logic            any;
  logic            tenancy_end;
  logic            guard_done;
  logic            decide;
  logic [3:0]      cnt_inc;

  rr_pick8 u_pick (
    .req (req),
    .ptr (ptr),
    .win (win),
    .any (any)
  );

  // A request drop wins over expiry; both end the tenancy at this edge.
  assign tenancy_end = (state == S_GRANT) && (!req[sel] || (cnt == MB));
  assign guard_done  = (state == S_GUARD) && (gcnt == 2'd1);
  // Points where a fresh arbitration decision is taken at this edge.
  assign decide      = (state == S_IDLE) || guard_done ||
                       (tenancy_end && (GC == 2'd0));
  assign cnt_inc     = (cnt < MB) ? cnt + 4'd1 : cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      sel        <= '0;
      gnt        <= '0;
      vld        <= 1'b0;
      burst_last <= 1'b0;
      ptr        <= SELW'(NCH - 1);
      cnt        <= '0;
      gcnt       <= '0;
    end else if (decide) begin
      if (en && any) begin
        state      <= S_GRANT;
        sel        <= win;
        gnt        <= NCH'(1) << win;
        vld        <= 1'b1;
        cnt        <= 4'd1;
        ptr        <= win;
        burst_last <= (MB == 4'd1);
      end else begin
        state      <= S_IDLE;
        gnt        <= '0;
        vld        <= 1'b0;
        burst_last <= 1'b0;
        cnt        <= '0;
      end
    end else begin
      case (state)
        S_GRANT: begin
          if (tenancy_end) begin
            // sel holds its last value through the guard interval
            state      <= S_GUARD;
            gcnt       <= GC;
            gnt        <= '0;
            vld        <= 1'b0;
            burst_last <= 1'b0;
            cnt        <= '0;
          end else begin
            cnt        <= cnt_inc;
            burst_last <= (cnt_inc == MB);
          end
        end
        S_GUARD: begin
          gcnt <= gcnt - 2'd1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux8_sched.sv
// tb_rr_mux8_sched
//   Directed bench for rr_mux8_sched. Two instances share clk/rst/en/req:
//   u_dut uses the default parameters (MAX_BURST=4, GUARD_CYCLES=1) and
//   u_dut0 uses GUARD_CYCLES=0. Stimulus pushes the expected grant cycles
//   (select, burst_last and the count of idle cycles before each one) into
//   a queue; a negedge monitor pops an entry for every vld cycle of the
//   instance selected by 'which'.
module tb_rr_mux8_sched;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req;

  logic [2:0] sel_a, sel_b;
  logic [7:0] gnt_a, gnt_b;
  logic       vld_a, vld_b;
  logic       bl_a, bl_b;

  rr_mux8_sched u_dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req        (req),
    .sel        (sel_a),
    .gnt        (gnt_a),
    .vld        (vld_a),
    .burst_last (bl_a)
  );

  rr_mux8_sched #(.MAX_BURST(4), .GUARD_CYCLES(0)) u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req        (req),
    .sel        (sel_b),
    .gnt        (gnt_b),
    .vld        (vld_b),
    .burst_last (bl_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int         gap;
    logic [2:0] sel;
    logic       bl;
  } item_t;

  item_t q[$];
  int    total = 0;
  int    bad   = 0;
  int    gap   = 0;
  bit    which = 1'b0;

  logic [2:0] m_sel;
  logic [7:0] m_gnt;
  logic       m_vld;
  logic       m_bl;
  item_t      e;

  always @(negedge clk) begin
    if (rst) begin
      gap = 0;
    end else begin
      m_sel = which ? sel_b : sel_a;
      m_gnt = which ? gnt_b : gnt_a;
      m_vld = which ? vld_b : vld_a;
      m_bl  = which ? bl_b  : bl_a;
      total++;
      if (!$onehot0(m_gnt) || (m_vld != (|m_gnt)) ||
          ((m_gnt != 8'd0) && (m_gnt != (8'd1 << m_sel))) || (m_bl && !m_vld)) begin
        bad++;
        $display("FAIL invariant: got vld=%b gnt=%h sel=%0d bl=%b", m_vld, m_gnt, m_sel, m_bl);
      end
      if (m_vld) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_grant: got sel=%0d gnt=%h, want no grant", m_sel, m_gnt);
        end else begin
          e = q.pop_front();
          if ((gap != e.gap) || (m_sel != e.sel) || (m_gnt != (8'd1 << e.sel)) || (m_bl != e.bl)) begin
            bad++;
            $display("FAIL grant: got sel=%0d gnt=%h bl=%b gap=%0d, want sel=%0d gnt=%h bl=%b gap=%0d",
                     m_sel, m_gnt, m_bl, gap, e.sel, 8'd1 << e.sel, e.bl, e.gap);
          end
        end
        gap = 0;
      end else begin
        gap++;
      end
    end
  end

  task automatic exp(input int g, input logic [2:0] s, input logic b);
    item_t it;
    it.gap = g;
    it.sel = s;
    it.bl  = b;
    q.push_back(it);
  endtask

  // Returns at negedge+1 once every expected grant has been seen.
  task automatic drain(input int maxc);
    int n = 0;
    while (q.size() != 0 && n < maxc) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d pending grants, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic check_reset();
    total++;
    if ({sel_a, gnt_a, vld_a, bl_a} != 13'd0) begin
      bad++;
      $display("FAIL reset_a: got sel=%0d gnt=%h vld=%b bl=%b, want all 0", sel_a, gnt_a, vld_a, bl_a);
    end
    total++;
    if ({sel_b, gnt_b, vld_b, bl_b} != 13'd0) begin
      bad++;
      $display("FAIL reset_b: got sel=%0d gnt=%h vld=%b bl=%b, want all 0", sel_b, gnt_b, vld_b, bl_b);
    end
  endtask

  // Asserts reset asynchronously, checks outputs, then releases it at posedge+1.
  task automatic do_reset(input logic [7:0] r, input bit w);
    rst = 1'b1;
    #1;
    check_reset();
    which = w;
    req   = r;
    en    = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b1;
    req = 8'h00;
    #2;

    // single requester: 4-cycle bursts separated by one guard cycle
    do_reset(8'h01, 1'b0);
    exp(1, 3'd0, 1'b0); exp(0, 3'd0, 1'b0); exp(0, 3'd0, 1'b0); exp(0, 3'd0, 1'b1);
    exp(1, 3'd0, 1'b0); exp(0, 3'd0, 1'b0); exp(0, 3'd0, 1'b0); exp(0, 3'd0, 1'b1);
    drain(40);
    req = 8'h00;

    // ch0 / ch7 alternate
    do_reset(8'h81, 1'b0);
    for (int t = 0; t < 3; t++) begin
      for (int c = 0; c < 4; c++)
        exp((c == 0) ? 1 : 0, (t == 1) ? 3'd7 : 3'd0, c == 3);
    end
    drain(60);
    req = 8'h00;

    // early drop by ch2, then ch5
    do_reset(8'h24, 1'b0);
    exp(1, 3'd2, 1'b0); exp(0, 3'd2, 1'b0);
    drain(20);
    req = 8'h20;
    exp(1, 3'd5, 1'b0); exp(0, 3'd5, 1'b0);
    drain(20);
    req = 8'h00;

    // no guard: back-to-back tenancies with vld held high
    do_reset(8'h0C, 1'b1);
    exp(1, 3'd2, 1'b0); exp(0, 3'd2, 1'b0); exp(0, 3'd2, 1'b0); exp(0, 3'd2, 1'b1);
    exp(0, 3'd3, 1'b0); exp(0, 3'd3, 1'b0); exp(0, 3'd3, 1'b0); exp(0, 3'd3, 1'b1);
    exp(0, 3'd2, 1'b0);
    drain(40);
    req = 8'h00;

    // en dropped mid-tenancy of ch1; ch4 waits until en returns
    do_reset(8'h12, 1'b0);
    exp(1, 3'd1, 1'b0); exp(0, 3'd1, 1'b0);
    drain(20);
    en = 1'b0;
    exp(0, 3'd1, 1'b0); exp(0, 3'd1, 1'b1);
    drain(20);
    repeat (5) @(negedge clk);
    exp(5, 3'd4, 1'b0); exp(0, 3'd4, 1'b0);
    en = 1'b1;
    drain(20);
    req = 8'h00;

    // reset during ch6 tenancy; priority restarts from ch0
    do_reset(8'h40, 1'b0);
    exp(1, 3'd6, 1'b0); exp(0, 3'd6, 1'b0);
    drain(20);
    do_reset(8'h41, 1'b0);
    exp(1, 3'd0, 1'b0); exp(0, 3'd0, 1'b0);
    drain(20);
    req = 8'h00;

    repeat (6) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
